isq_issue_select: RTL and testbench

Dequeue side of the issue queue.
- Watches the `ready_to_dequeue_out` of every condition-queue entry and picks one ready entry per cycle in round-robin order.
- Pulses that entry's `clear_entry` so the entry frees itself at the same clock edge.
- Presents the captured payload to the execution pipe on a registered valid/ready output stage.
- Sits between the array of queue entries and the functional-unit dispatch port.

---
 rtl/isq_issue_select.sv | 80 ++++++++
 tb/tb_isq_issue_select.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/isq_issue_select.sv
// Issue-queue dequeue side: round-robin pick of one ready entry per cycle,
// same-cycle clear pulse, and a registered valid/ready output stage.
module isq_issue_select #(
    parameter int ENTRIES = 8,
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 6,
    parameter int PTR_W   = $clog2(ENTRIES)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [ENTRIES-1:0]         entry_ready,
    input  logic [ENTRIES*DATA_W-1:0]  entry_data,
    input  logic [ENTRIES*INDEX_W-1:0] entry_index,
    output logic [ENTRIES-1:0]         clear_entry,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [DATA_W-1:0]          issue_data,
    output logic [INDEX_W-1:0]         issue_index,
    output logic [PTR_W-1:0]           issue_entry
);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   scan;
    logic               pick_found;
    logic               pick_valid;
    logic               can_take;
    logic               capture;
    logic [DATA_W-1:0]  pick_data;
    logic [INDEX_W-1:0] pick_index;

    // Scan upward from rr_ptr; pointer arithmetic wraps since ENTRIES is 2^n.
    always_comb begin
        pick       = '0;
        scan       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            scan = rr_ptr + PTR_W'(k);
            if (!pick_found && entry_ready[scan]) begin
                pick       = scan;
                pick_found = 1'b1;
            end
        end
    end

    assign pick_valid = |entry_ready;
    assign can_take   = (!issue_valid || issue_ready) && !flush;
    assign capture    = can_take && pick_valid && !reset;
    assign pick_data  = entry_data[pick*DATA_W +: DATA_W];
    assign pick_index = entry_index[pick*INDEX_W +: INDEX_W];

    always_comb begin
        clear_entry = '0;
        if (capture) begin
            clear_entry = ENTRIES'(1) << pick;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_data  <= '0;
            issue_index <= '0;
            issue_entry <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (capture) begin
            issue_valid <= 1'b1;
            issue_data  <= pick_data;
            issue_index <= pick_index;
            issue_entry <= pick;
            rr_ptr      <= pick + 1'b1;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_isq_issue_select.sv
// Directed bench for isq_issue_select with hand-computed expectations.
module tb_isq_issue_select;

    localparam int ENTRIES = 8;
    localparam int DATA_W  = 64;
    localparam int INDEX_W = 6;
    localparam int PTR_W   = 3;

    logic                       clock;
    logic                       reset;
    logic                       flush;
    logic [ENTRIES-1:0]         entry_ready;
    logic [ENTRIES*DATA_W-1:0]  entry_data;
    logic [ENTRIES*INDEX_W-1:0] entry_index;
    logic [ENTRIES-1:0]         clear_entry;
    logic                       issue_valid;
    logic                       issue_ready;
    logic [DATA_W-1:0]          issue_data;
    logic [INDEX_W-1:0]         issue_index;
    logic [PTR_W-1:0]           issue_entry;

    int n_tests = 0;
    int n_fail  = 0;

    isq_issue_select #(
        .ENTRIES(ENTRIES),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .PTR_W  (PTR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .entry_ready(entry_ready),
        .entry_data (entry_data),
        .entry_index(entry_index),
        .clear_entry(clear_entry),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_data (issue_data),
        .issue_index(issue_index),
        .issue_entry(issue_entry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [63:0] d,
                             input logic [5:0] x);
        entry_data[i*DATA_W +: DATA_W]    = d;
        entry_index[i*INDEX_W +: INDEX_W] = x;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    int order [6] = '{1, 3, 6, 1, 3, 6};
    logic [7:0] one8;
    logic [63:0] d;

    initial begin
        one8        = 8'h01;
        reset       = 1'b1;
        flush       = 1'b0;
        issue_ready = 1'b1;
        entry_data  = '0;
        entry_index = '0;
        for (int i = 0; i < ENTRIES; i++)
            set_entry(i, 64'h1000 + 64'(i), 6'(i + 8));
        set_entry(2, 64'hAB, 6'd5);
        entry_ready = 8'h04;
        #3;
        chk("rst_clear", clear_entry, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_data", issue_data, 0);
        chk("rst_index", issue_index, 0);
        chk("rst_entry", issue_entry, 0);
        chk("rst_ptr", dut.rr_ptr, 0);

        // single entry
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("single_clear", clear_entry, 8'h04);
        tick();
        entry_ready = 8'h00;
        chk("single_valid", issue_valid, 1);
        chk("single_data", issue_data, 64'hAB);
        chk("single_index", issue_index, 5);
        chk("single_entry", issue_entry, 2);
        chk("single_ptr", dut.rr_ptr, 3);
        set_entry(2, 64'h1002, 6'd10);

        // round-robin fairness with entries 1,3,6 always ready
        do_reset();
        entry_ready = 8'h4A;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("rr_clear", clear_entry, one8 << order[j]);
            tick();
            chk("rr_entry", issue_entry, 64'(order[j]));
            chk("rr_data", issue_data, 64'h1000 + 64'(order[j]));
        end

        // backpressure
        do_reset();
        entry_ready = 8'h01;
        #1;
        chk("bp_clear0", clear_entry, 8'h01);
        tick();
        entry_ready = 8'h10;
        issue_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_stall_clear", clear_entry, 0);
            tick();
            chk("bp_stall_valid", issue_valid, 1);
            chk("bp_stall_data", issue_data, 64'h1000);
            chk("bp_stall_ptr", dut.rr_ptr, 1);
        end
        issue_ready = 1'b1;
        #1;
        chk("bp_release_clear", clear_entry, 8'h10);
        tick();
        chk("bp_entry", issue_entry, 4);
        chk("bp_data", issue_data, 64'h1004);
        chk("bp_ptr", dut.rr_ptr, 5);

        // wrap: bring pointer to 7, then only entry 0 ready
        entry_ready = 8'h40;
        #1;
        chk("wrap_pre_clear", clear_entry, 8'h40);
        tick();
        chk("wrap_pre_ptr", dut.rr_ptr, 7);
        entry_ready = 8'h01;
        #1;
        chk("wrap_clear", clear_entry, 8'h01);
        tick();
        chk("wrap_entry", issue_entry, 0);
        chk("wrap_ptr", dut.rr_ptr, 1);

        // flush with a valid output and entry 5 ready
        entry_ready = 8'h20;
        issue_ready = 1'b0;
        flush       = 1'b1;
        #1;
        chk("flush_clear", clear_entry, 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", issue_valid, 0);
        chk("flush_data_kept", issue_data, 64'h1000);
        chk("flush_ptr", dut.rr_ptr, 1);
        #1;
        chk("post_flush_clear", clear_entry, 8'h20);
        tick();
        chk("post_flush_valid", issue_valid, 1);
        chk("post_flush_entry", issue_entry, 5);

        // async reset during a stall
        entry_ready = 8'h02;
        issue_ready = 1'b0;
        #2;
        chk("stall_valid", issue_valid, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", issue_valid, 0);
        chk("arst_data", issue_data, 0);
        chk("arst_entry", issue_entry, 0);
        chk("arst_clear", clear_entry, 0);
        chk("arst_ptr", dut.rr_ptr, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
